// File: rtl/combo_pkg.sv
// Shared constants and helpers for the button-combo decoders, so the plain
// combinational decoder and the clocked one agree on width and bit mapping.
package combo_pkg;

    localparam int N_IN_DEF     = 3;
    localparam int DEBOUNCE_DEF = 4;
    localparam int N_IN_MAX     = 6;

    // Width of the debounce counter: enough for DEBOUNCE_CYCLES-1, never below 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic logic [2**N_IN_MAX-1:0] onehot_decode(input logic [N_IN_MAX-1:0] idx);
        return {{(2**N_IN_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/combo_decoder_sync_input_sync.sv
// Multi-flop synchroniser for asynchronous board inputs; clears to 0 on reset.
module input_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/combo_decoder_sync.sv
// Clocked button-combo decoder: synchronise, debounce the whole vector as one
// unit, then register a gated one-hot, a binary index and a change strobe.
module combo_decoder_sync
    import combo_pkg::*;
#(
    parameter int N_IN            = N_IN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_IN-1:0]      btn_in,
    output logic [2**N_IN-1:0]   combo_onehot,
    output logic [N_IN-1:0]      combo_idx,
    output logic                 combo_strobe
);

    localparam int              OH_W    = 2**N_IN;
    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0] syncd;
    logic [N_IN-1:0] cand,   cand_next;
    logic [CW-1:0]   cnt,    cnt_next;
    logic [N_IN-1:0] stable, stable_next;
    logic            accept;

    input_sync #(
        .WIDTH  (N_IN),
        .STAGES (SYNC_STAGES)
    ) u_input_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (syncd)
    );

    // Any change of the synchronised vector restarts the count; the candidate
    // is accepted only once the count has saturated.
    always_comb begin
        cand_next   = cand;
        cnt_next    = cnt;
        stable_next = stable;
        accept      = 1'b0;
        if (syncd != cand) begin
            cand_next = syncd;
            cnt_next  = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CW'(1);
        end else if (cand != stable) begin
            stable_next = cand;
            accept      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            cand   <= cand_next;
            cnt    <= cnt_next;
            stable <= stable_next;
        end
    end

    // Outputs follow stable_next so they land on the same edge as the accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo_onehot <= '0;
            combo_idx    <= '0;
            combo_strobe <= 1'b0;
        end else begin
            combo_idx    <= stable_next;
            combo_onehot <= enable ? OH_W'(onehot_decode(N_IN_MAX'(stable_next))) : '0;
            combo_strobe <= accept & enable;
        end
    end

endmodule

// File: doc/combo_decoder_sync.md
Name: combo_decoder_sync

Overview:
- Clocked, parametrised successor to the combinational 3-to-8 button-combo decoder.
- Takes N_IN raw, asynchronous button/joystick lines and synchronises them into the clock domain.
- Debounces the whole input vector as one unit, then registers a one-hot combo output with a gate enable.
- Emits a single-cycle strobe on every accepted combo change. Sits between the board's button pins and the downstream mux/control logic.

Parameters:
- N_IN, 3, number of raw button inputs; the one-hot output is 2**N_IN wide; legal range 1..6.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised vector must hold before it is accepted; legal range 1..65535.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; legal range 2..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- enable  input  1  output gate, sampled synchronously.
- btn_in  input  N_IN  raw asynchronous buttons; bit N_IN-1 is "up"-equivalent MSB, bit 0 is LSB.
- combo_onehot  output  2**N_IN  registered one-hot decode of the accepted combo; all zeros when gated off.
- combo_idx  output  N_IN  registered binary index of the accepted combo; not gated by enable.
- combo_strobe  output  1  one-cycle pulse on each accepted combo change while enabled.

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser flops, cand, cnt, stable and all outputs clear to 0.
  - combo_onehot = 0, combo_idx = 0, combo_strobe = 0.
  - Reset mid-debounce discards the pending candidate and produces no strobe.
- Synchroniser: SYNC_STAGES-deep shift of btn_in; the final stage is called syncd.
- Debounce registers:
  - cand: N_IN bits.
  - cnt: clog2(DEBOUNCE_CYCLES), minimum 1 bit.
  - stable: N_IN bits.
- Debounce update, every edge, priority order:
  - syncd != cand → cand <= syncd, cnt <= 0.
  - else cnt != DEBOUNCE_CYCLES-1 → cnt <= cnt+1.
  - else cand != stable → stable <= cand (this is the "accept" event).
  - else hold.
- Latency: btn_in changes and then stays constant. stable, combo_idx and combo_onehot update on the (SYNC_STAGES + DEBOUNCE_CYCLES + 1)th rising edge after the change. This is 7 edges for the defaults.
- Glitch rejection: a change that reverts before cnt reaches DEBOUNCE_CYCLES-1 restarts the count; stable is untouched.
  - If cand returns to the value already held in stable, nothing is accepted and no strobe fires.
- Output registers, every edge:
  - combo_idx <= stable_next, the value stable takes on this edge.
  - combo_onehot <= enable ? (1 << stable_next) : 0. Exactly one bit is set when enabled.
  - combo_strobe <= accept AND enable. It is high for exactly one cycle and never asserts for two consecutive cycles.
- Enable:
  - Sampled each edge; takes effect on the next edge (1-cycle latency).
  - Debouncing and stable/combo_idx tracking continue while enable = 0.
  - Re-enabling restores the one-hot of the current stable combo with no strobe.
- Simultaneous events: an accept on the same edge enable falls gives onehot = 0 and no strobe, while combo_idx still updates.
- After reset release with btn_in = 0 and enable = 1, combo_onehot becomes bit 0 on the first edge, with no strobe.
- All arithmetic is unsigned; cnt saturates at DEBOUNCE_CYCLES-1 and never wraps.

Decomposition:
- Shared package combo_pkg holds:
  - Default constants N_IN_DEF = 3 and DEBOUNCE_DEF = 4.
  - A width function for the cnt register.
  - A one-hot decode function, so the combinational decoder and this block use the same mapping.
- One natural sub-module: input_sync, parametrised by WIDTH and STAGES, with async active-high reset to 0. Reuse it for all board inputs.

Test Plan (defaults unless stated):
- rst = 1 with btn_in = 101 → all outputs 0 with no clock edge needed. Release with btn_in = 000, enable = 1 → combo_onehot = 8'h01 after the first edge, combo_strobe never asserts.
- btn_in 000→101 and held → combo_idx = 5 and combo_onehot = 8'h20 on edge 7. combo_strobe is high exactly on that edge's cycle; cycles 6 and 8 are low.
- From stable 101: btn_in = 111 for 3 cycles then back to 101 → combo_idx stays 5, no strobe. Then 111 held → combo_idx = 7, onehot = 8'h80, one strobe.
- enable = 0 → combo_onehot = 0 next edge. Then btn_in = 011 → combo_idx = 3, no strobe, onehot stays 0. Then enable = 1 → onehot = 8'h08 next edge, no strobe.
- Assert rst asynchronously while cnt = 2 during a 000→110 change → outputs 0 immediately. After release with btn_in = 110, accept occurs a full 7 edges later.
- Build with N_IN = 4, DEBOUNCE_CYCLES = 1, SYNC_STAGES = 3: btn_in = 1111 → combo_onehot = 16'h8000 and combo_idx = 15 on edge 5, with one strobe.
